ram_access_arbiter: RTL

- Two-client arbiter that shares one 16x8 dual-port RAM (one write port, one read port, registered read data) between requesters A and B.
- Each cycle it issues at most one write and one read to the RAM, so a write from one client and a read from the other proceed concurrently.
- Same-type contention is resolved round-robin, with a separate pointer per port.
- Read data is routed back to the issuing client with a valid strobe.

---
 rtl/ram_access_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/ram_access_arbiter.sv
// Two-client arbiter in front of a 16x8 dual-port RAM: one write and one read
// per cycle, round-robin per port on same-type contention, tagged read return.
module ram_access_arbiter #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,

    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,

    output logic          ram_wr_en,
    output logic [AW-1:0] ram_wr_addr,
    output logic [DW-1:0] ram_wr_data,
    output logic          ram_rd_en,
    output logic [AW-1:0] ram_rd_addr,
    input  logic [DW-1:0] ram_rdata
);

    typedef enum logic {
        CLI_A = 1'b0,
        CLI_B = 1'b1
    } client_e;

    client_e       wr_ptr_q, wr_ptr_d;
    client_e       rd_ptr_q, rd_ptr_d;
    logic          ram_wr_en_q, ram_wr_en_d;
    logic [AW-1:0] ram_wr_addr_q, ram_wr_addr_d;
    logic [DW-1:0] ram_wr_data_q, ram_wr_data_d;
    logic          ram_rd_en_q, ram_rd_en_d;
    logic [AW-1:0] ram_rd_addr_q, ram_rd_addr_d;
    client_e       rd_tag_q, rd_tag_d;
    logic          a_rvalid_q, a_rvalid_d;
    logic          b_rvalid_q, b_rvalid_d;

    // Candidates are masked by reset so no grant can be seen while rst is low
    logic a_wr_c, b_wr_c, a_rd_c, b_rd_c;
    logic a_wgnt_c, b_wgnt_c, a_rgnt_c, b_rgnt_c;

    // Candidate decode
    always_comb begin
        a_wr_c = rst & a_req &  a_we;
        b_wr_c = rst & b_req &  b_we;
        a_rd_c = rst & a_req & ~a_we;
        b_rd_c = rst & b_req & ~b_we;
    end

    // Per-port round-robin grant; pointer only moves on a contested grant
    always_comb begin
        a_wgnt_c = 1'b0;
        b_wgnt_c = 1'b0;
        a_rgnt_c = 1'b0;
        b_rgnt_c = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        if (a_wr_c && b_wr_c) begin
            a_wgnt_c = (wr_ptr_q == CLI_A);
            b_wgnt_c = (wr_ptr_q == CLI_B);
            wr_ptr_d = (wr_ptr_q == CLI_A) ? CLI_B : CLI_A;
        end else begin
            a_wgnt_c = a_wr_c;
            b_wgnt_c = b_wr_c;
        end

        if (a_rd_c && b_rd_c) begin
            a_rgnt_c = (rd_ptr_q == CLI_A);
            b_rgnt_c = (rd_ptr_q == CLI_B);
            rd_ptr_d = (rd_ptr_q == CLI_A) ? CLI_B : CLI_A;
        end else begin
            a_rgnt_c = a_rd_c;
            b_rgnt_c = b_rd_c;
        end
    end

    // Issue stage: register granted commands; addr/data hold when idle
    always_comb begin
        ram_wr_en_d   = a_wgnt_c | b_wgnt_c;
        ram_wr_addr_d = ram_wr_addr_q;
        ram_wr_data_d = ram_wr_data_q;
        ram_rd_en_d   = a_rgnt_c | b_rgnt_c;
        ram_rd_addr_d = ram_rd_addr_q;
        rd_tag_d      = rd_tag_q;

        if (a_wgnt_c) begin
            ram_wr_addr_d = a_addr;
            ram_wr_data_d = a_wdata;
        end else if (b_wgnt_c) begin
            ram_wr_addr_d = b_addr;
            ram_wr_data_d = b_wdata;
        end

        if (a_rgnt_c) begin
            ram_rd_addr_d = a_addr;
            rd_tag_d      = CLI_A;
        end else if (b_rgnt_c) begin
            ram_rd_addr_d = b_addr;
            rd_tag_d      = CLI_B;
        end
    end

    // Return stage: RAM data appears the cycle after ram_rd_en, steer valid by tag
    always_comb begin
        a_rvalid_d = ram_rd_en_q & (rd_tag_q == CLI_A);
        b_rvalid_d = ram_rd_en_q & (rd_tag_q == CLI_B);
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q      <= CLI_A;
            rd_ptr_q      <= CLI_A;
            ram_wr_en_q   <= 1'b0;
            ram_wr_addr_q <= '0;
            ram_wr_data_q <= '0;
            ram_rd_en_q   <= 1'b0;
            ram_rd_addr_q <= '0;
            rd_tag_q      <= CLI_A;
            a_rvalid_q    <= 1'b0;
            b_rvalid_q    <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            ram_wr_en_q   <= ram_wr_en_d;
            ram_wr_addr_q <= ram_wr_addr_d;
            ram_wr_data_q <= ram_wr_data_d;
            ram_rd_en_q   <= ram_rd_en_d;
            ram_rd_addr_q <= ram_rd_addr_d;
            rd_tag_q      <= rd_tag_d;
            a_rvalid_q    <= a_rvalid_d;
            b_rvalid_q    <= b_rvalid_d;
        end
    end

    assign a_gnt       = a_wgnt_c | a_rgnt_c;
    assign b_gnt       = b_wgnt_c | b_rgnt_c;
    assign a_rvalid    = a_rvalid_q;
    assign b_rvalid    = b_rvalid_q;
    assign a_rdata     = ram_rdata;
    assign b_rdata     = ram_rdata;
    assign ram_wr_en   = ram_wr_en_q;
    assign ram_wr_addr = ram_wr_addr_q;
    assign ram_wr_data = ram_wr_data_q;
    assign ram_rd_en   = ram_rd_en_q;
    assign ram_rd_addr = ram_rd_addr_q;

endmodule
